// File: rtl/sys_clk_reset_gen.sv
// sys_clk_reset_gen: PLL lock synchroniser, settle-gated system reset and pixel/CPU clock enables.
module sys_clk_reset_gen #(
  parameter int SETTLE_CYCLES = 1024,
  parameter int PIX_DIV = 39,
  parameter int CPU_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic lock,
  output logic rst_out,
  output logic ce_pix,
  output logic ce_cpu,
  output logic lock_lost
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(PIX_DIV);
  localparam int CW = $clog2(CPU_DIV + 1);
  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;
  state_t state, next;
  logic lock_m, lock_s, stay_run, pix_hit;
  logic [SW-1:0] settle_cnt;
  logic [PW-1:0] pix_cnt;
  logic [CW-1:0] cpu_cnt;
  always_comb begin
    next = !lock_s ? WAIT_LOCK :
           state == WAIT_LOCK ? SETTLE :
           (state == SETTLE && settle_cnt == SW'(SETTLE_CYCLES - 1)) ? RUN : state;
    stay_run = state == RUN && next == RUN;
    // enables are registered, so decode one count early to land ce_pix on RUN cycle PIX_DIV
    pix_hit = stay_run && pix_cnt == PW'(PIX_DIV - 2);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_LOCK;
      lock_m     <= 1'b0;
      lock_s     <= 1'b0;
      settle_cnt <= '0;
      pix_cnt    <= '0;
      cpu_cnt    <= '0;
      rst_out    <= 1'b1;
      ce_pix     <= 1'b0;
      ce_cpu     <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      lock_m     <= lock;
      lock_s     <= lock_m;
      state      <= next;
      settle_cnt <= (state == SETTLE && next == SETTLE) ? settle_cnt + 1'b1 : '0;
      rst_out    <= next != RUN;
      pix_cnt    <= !stay_run ? '0 : pix_cnt == PW'(PIX_DIV - 1) ? '0 : pix_cnt + 1'b1;
      cpu_cnt    <= !stay_run ? '0 : !pix_hit ? cpu_cnt :
                    cpu_cnt == CW'(CPU_DIV - 1) ? '0 : cpu_cnt + 1'b1;
      ce_pix     <= pix_hit;
      ce_cpu     <= pix_hit && cpu_cnt == CW'(CPU_DIV - 1);
      lock_lost  <= lock_lost | (state == RUN && !lock_s);
    end
  end
endmodule

// File: tb/tb_sys_clk_reset_gen.sv
// tb_sys_clk_reset_gen: table, random and corner-case checks of three parameterisations against a behavioural model.
module tb_sys_clk_reset_gen;
  localparam int S = 8;
  logic clk, reset, lock;
  logic a_rst, a_pix, a_cpu, a_lost;
  logic b_rst, b_pix, b_cpu, b_lost;
  logic c_rst, c_pix, c_cpu, c_lost;
  int passed = 0, total = 0;
  logic p1, p2;
  int streak, k;
  bit run, lost;

  sys_clk_reset_gen #(.SETTLE_CYCLES(S), .PIX_DIV(4), .CPU_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .lock(lock),
    .rst_out(a_rst), .ce_pix(a_pix), .ce_cpu(a_cpu), .lock_lost(a_lost));
  sys_clk_reset_gen #(.SETTLE_CYCLES(S), .PIX_DIV(39), .CPU_DIV(2)) dut_b (
    .clk(clk), .reset(reset), .lock(lock),
    .rst_out(b_rst), .ce_pix(b_pix), .ce_cpu(b_cpu), .lock_lost(b_lost));
  sys_clk_reset_gen #(.SETTLE_CYCLES(S), .PIX_DIV(4), .CPU_DIV(1)) dut_c (
    .clk(clk), .reset(reset), .lock(lock),
    .rst_out(c_rst), .ce_pix(c_pix), .ce_cpu(c_cpu), .lock_lost(c_lost));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s got %0d expected %0d", name, act, exp);
  endtask

  // Model: RUN once the synchronised lock has been seen high on SETTLE_CYCLES+1 consecutive edges;
  // k is the 1-based RUN cycle index, enables fall on multiples of the divide ratios.
  task automatic step(input logic r, input logic l);
    logic ls;
    bit was;
    reset = r;
    lock = l;
    @(posedge clk);
    if (r) begin
      p1 = 0; p2 = 0; streak = 0; run = 0; k = 0; lost = 0;
    end else begin
      ls = p2; p2 = p1; p1 = l;
      was = run;
      streak = ls ? streak + 1 : 0;
      run = streak >= S + 1;
      if (was && !run) lost = 1;
      k = run ? k + 1 : 0;
    end
    #1;
    chk("a_rst", a_rst, !run);
    chk("a_pix", a_pix, run && k % 4 == 0);
    chk("a_cpu", a_cpu, run && k % 8 == 0);
    chk("a_lost", a_lost, lost);
    chk("b_rst", b_rst, !run);
    chk("b_pix", b_pix, run && k % 39 == 0);
    chk("b_cpu", b_cpu, run && k % 78 == 0);
    chk("b_lost", b_lost, lost);
    chk("c_pix", c_pix, run && k % 4 == 0);
    chk("c_cpu_eq_pix", c_cpu, c_pix);
    chk("c_rst", c_rst, !run);
    chk("c_lost", c_lost, lost);
  endtask

  typedef struct {
    logic r, l, e_rst, e_pix, e_cpu, e_lost;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int n, npix, ncpu;
    bit prev, bad_coinc, bad_dup;
    reset = 1;
    lock = 0;
    // first-lock sequence: 3 reset cycles, 10 settling edges, then RUN cycles 1..16
    repeat (3) tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    repeat (10) tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    for (int i = 1; i <= 16; i++)
      tbl.push_back('{1'b0, 1'b1, 1'b0, logic'(i == 4 || i == 8 || i == 12 || i == 16),
                      logic'(i == 8 || i == 16), 1'b0});
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].l);
      chk("tbl_rst", a_rst, tbl[i].e_rst);
      chk("tbl_pix", a_pix, tbl[i].e_pix);
      chk("tbl_cpu", a_cpu, tbl[i].e_cpu);
      chk("tbl_lost", a_lost, tbl[i].e_lost);
    end

    // lock glitch during settle restarts the count
    step(1, 0); step(1, 0);
    repeat (5) step(0, 1);
    step(0, 0);
    n = 0;
    do begin step(0, 1); n++; end while (a_rst && n < 50);
    chk_int("glitch_relock_edges", n, 11);
    chk("glitch_lost", a_lost, 1'b0);
    repeat (12) step(0, 1);

    // lock loss in RUN for 3 cycles
    n = 0;
    do begin step(0, 0); n++; end while (!a_rst && n < 3);
    chk_int("loss_edges", n, 3);
    chk("loss_lost", a_lost, 1'b1);
    n = 0;
    do begin step(0, 1); n++; end while (a_rst && n < 50);
    chk_int("relock_edges", n, 11);
    repeat (20) step(0, 1);
    chk("lost_sticky", a_lost, 1'b1);

    // reset mid-RUN
    step(1, 1);
    chk("mid_reset_rst", a_rst, 1'b1);
    chk("mid_reset_lost", a_lost, 1'b0);
    n = 0;
    do begin step(0, 1); n++; end while (a_rst && n < 50);
    chk_int("after_reset_edges", n, 11);

    // reset coinciding with lock loss keeps lock_lost clear
    repeat (5) step(0, 1);
    step(1, 0);
    step(0, 0); step(0, 0); step(0, 0);
    chk("reset_with_loss_lost", a_lost, 1'b0);

    // randomized lock/reset activity
    lock = 1;
    for (int i = 0; i < 2000; i++) begin
      logic nl;
      nl = ($urandom_range(0, 99) < 3) ? !lock : lock;
      step(logic'($urandom_range(0, 199) == 0), nl);
    end

    // long run on the 39/2 divider
    step(1, 1);
    n = 0;
    do begin step(0, 1); n++; end while (b_rst && n < 50);
    chk("long_run_entered", b_rst, 1'b0);
    npix = 0; ncpu = 0; prev = 0; bad_coinc = 0; bad_dup = 0;
    for (int i = 1; i <= 10000; i++) begin
      npix += int'(b_pix);
      ncpu += int'(b_cpu);
      if (b_cpu && !b_pix) bad_coinc = 1;
      if (prev && (b_pix || b_cpu)) bad_dup = 1;
      prev = b_pix || b_cpu;
      if (i < 10000) step(0, 1);
    end
    chk_int("long_pix_count", npix, 256);
    chk_int("long_cpu_count", ncpu, 128);
    chk("long_cpu_coincident", bad_coinc, 1'b0);
    chk("long_no_consecutive", bad_dup, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
